seg_pipe_cpa: RTL
=================

Name: seg_pipe_cpa

Overview:
- Parametrised, pipelined carry-propagate adder/subtractor that succeeds the fixed-width combinational ripple CPA used at the end of the multiplier reduction tree.
- The operand width is split into SEG_W-bit segments. One segment resolves per pipeline stage, with the carry registered between stages.
- Sustains one operation per cycle at a clock rate set by SEG_W rather than the full operand width.
- Has a valid/ready handshake and full-pipeline backpressure, so it drops into streaming multiplier or MAC datapaths.

Parameters:
- WIDTH, 63, operand and sum width in bits (>=1).
- SEG_W, 16, segment width per pipeline stage (>=1). NSEG = ceil(WIDTH/SEG_W); the last segment is WIDTH-(NSEG-1)*SEG_W bits.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b; 1: a-b, computed as a+~b+1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.

Behaviour:
- Reset: all stage valid bits cleared; out_valid=0, sum=0, cout=0. in_ready=1 the cycle after rst deasserts. Reset asserted mid-operation discards every in-flight operation; there is no partial output.
- Global advance:
  - adv = ~out_valid | out_ready.
  - in_ready = adv; this is combinational and has no dependency on in_valid.
  - Accept = in_valid & in_ready.
  - When adv=0, every stage register holds, including the operand skew registers.
  - When adv=1, every stage shifts one position. An empty input slot enters as a bubble with valid=0.
- Latency:
  - An operation accepted at edge k has out_valid=1 after edge k+NSEG-1. Example: accept at cycle 0 gives out_valid at cycle NSEG-1 (the accepting edge is stage 0's register).
  - Throughput is 1 operation/cycle when out_ready=1.
- Stage s (0..NSEG-1):
  - Adds segment s of a and of b (b inverted when sub=1) plus the carry registered from stage s-1.
  - Stage 0 carry-in = registered sub.
  - Upper, not-yet-processed operand segments and the already-computed lower sum segments travel in skew registers alongside, together with the sub bit.
  - The segment adder is a plain ripple/behavioural '+'; carry-out is registered for stage s+1.
- Output:
  - sum and cout are registered and stable while out_valid=1 and out_ready=0.
  - sum, cout and the optional ovf do not change while out_valid=0 and adv=0. Their value while out_valid=0 is otherwise don't-care, except at reset.
- Arithmetic:
  - sum = (a + (sub ? ~b : b) + sub) mod 2^WIDTH.
  - cout = bit WIDTH of that sum. For sub=1, cout=1 means a>=b unsigned, i.e. no borrow.
- Degenerate case SEG_W>=WIDTH: NSEG=1, a single registered stage with latency 1 cycle.
- Simultaneous accept and output pop in the same cycle is legal and loses nothing.
- Ordering is strictly FIFO.

Optional Feature:
- Macro SEG_PIPE_CPA_OVF_EN.
- Defined:
  - Adds port ovf, out, 1 bit.
  - ovf = signed two's-complement overflow of the operation = carry into bit WIDTH-1 XOR cout.
  - Registered and aligned with sum; reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=63, SEG_W=16, NSEG=4 unless stated):
1. a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0, out_ready=1, accept at cycle 0 -> out_valid at cycle 3 only, sum=0, cout=1.
2. a=5, b=7, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFE, cout=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
3. Stream 8 back-to-back random ops with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 3, matching a golden model in order. Then hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while out_valid=1, sum held stable, no op lost or duplicated, order preserved after release.
4. Fill the pipeline with 3 ops and assert rst for one cycle -> out_valid=0 and sum=0, cout=0 after that edge. No stale results appear afterwards, and the first post-reset op has full 4-cycle latency.
5. WIDTH=8, SEG_W=8 (NSEG=1): a=0xFF, b=0x01 -> sum=0x00, cout=1, one cycle after accept. WIDTH=10, SEG_W=4 (segments 4,4,2): a=0x3FF, b=0x001 -> sum=0, cout=1 at latency 3.
6. With SEG_PIPE_CPA_OVF_EN defined: a=0x3FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> ovf=1, cout=0. Then a=0, b=1, sub=1 -> ovf=0, sum=all ones, cout=0.

Source files
------------

// File: rtl/seg_pipe_cpa.sv
// ============================================================================
//  Module      : seg_pipe_cpa
//  Description : Pipelined, segmented carry-propagate adder/subtractor with a
//                valid/ready handshake and whole-pipeline backpressure.
//                One SEG_W-bit segment resolves per stage; the inter-segment
//                carry is registered between stages.
//                Optional macro SEG_PIPE_CPA_OVF_EN adds the signed-overflow
//                output port ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_pipe_cpa #(
    parameter int WIDTH = 63,
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SEG_PIPE_CPA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NSEG = (WIDTH + SEG_W - 1) / SEG_W;

    // Upper bit boundary (exclusive) of segment s.
    function automatic int hi_of(input int s);
        return ((s + 1) * SEG_W > WIDTH) ? WIDTH : (s + 1) * SEG_W;
    endfunction

    // Offset of stage s in the packed stage-data bus. Stage s stores the
    // resolved low sum bits [HI-1:0] plus the unprocessed upper bits of a and
    // of the (possibly inverted) b, i.e. 2*WIDTH-HI bits.
    function automatic int doff(input int s);
        int acc;
        acc = 0;
        for (int t = 0; t < s; t++) begin
            acc = acc + 2 * WIDTH - hi_of(t);
        end
        return acc;
    endfunction

    localparam int DTOT = doff(NSEG);

    wire [DTOT-1:0] data_w;
    wire [NSEG-1:0] valid_w;
    wire [NSEG-1:0] carry_w;
    logic           adv;

    // A single advance signal moves or freezes the whole pipeline.
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_w[NSEG-1];
    assign cout      = carry_w[NSEG-1];
    assign sum       = data_w[doff(NSEG-1) +: WIDTH];

    for (genvar s = 0; s < NSEG; s++) begin : g_stage
        localparam int LO    = s * SEG_W;
        localparam int HI    = hi_of(s);
        localparam int SW    = HI - LO;
        localparam int RW_IN = WIDTH - LO;
        localparam int DW    = 2 * WIDTH - HI;

        logic [RW_IN-1:0] a_in;
        logic [RW_IN-1:0] b_in;
        logic             c_in;
        logic             v_in;
        logic [HI-1:0]    sum_new;
        logic [SW:0]      seg_res;
        logic [DW-1:0]    data_d;
        logic [DW-1:0]    data_q;
        logic             valid_q;
        logic             carry_q;

        if (s == 0) begin : g_first
            // Subtraction is a + ~b + 1: invert b once, inject sub as carry-in.
            assign a_in    = a;
            assign b_in    = sub ? ~b : b;
            assign c_in    = sub;
            assign v_in    = in_valid;
            assign sum_new = seg_res[SW-1:0];
        end else begin : g_next
            localparam int PDW = 2 * WIDTH - LO;
            logic [PDW-1:0] prev;
            assign prev    = data_w[doff(s-1) +: PDW];
            assign a_in    = prev[LO +: RW_IN];
            assign b_in    = prev[WIDTH +: RW_IN];
            assign c_in    = carry_w[s-1];
            assign v_in    = valid_w[s-1];
            assign sum_new = {seg_res[SW-1:0], prev[LO-1:0]};
        end

        assign seg_res = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

        if (s < NSEG - 1) begin : g_skew
            assign data_d = {b_in[RW_IN-1:SW], a_in[RW_IN-1:SW], sum_new};
        end else begin : g_last
            assign data_d = sum_new;
`ifdef SEG_PIPE_CPA_OVF_EN
            logic ovf_d;
            logic ovf_q;
            // Carry into the MSB xor carry out of the MSB.
            assign ovf_d = a_in[SW-1] ^ b_in[SW-1] ^ seg_res[SW-1] ^ seg_res[SW];
            // Overflow flag travels with the final sum register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end
            assign ovf = ovf_q;
`endif
        end

        // Stage register: shifts on advance, holds otherwise, cleared by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                data_q  <= '0;
            end else if (adv) begin
                valid_q <= v_in;
                carry_q <= seg_res[SW];
                data_q  <= data_d;
            end
        end

        assign data_w[doff(s) +: DW] = data_q;
        assign valid_w[s]            = valid_q;
        assign carry_w[s]            = carry_q;
    end

endmodule

`default_nettype wire
